if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage that directly feeds the IF/ID pipeline register.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake, one request outstanding at most.
- Buffers returned instructions in a small in-order prefetch queue and presents the head as if_pc/if_ins.
- Handles stall[0], branch redirects from ID (including a squashed in-flight fetch), and requests a pipeline stall when it has nothing to issue.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- QDEPTH, 4, prefetch queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit 0 = IF stage hold
- branch_flag  in  1  redirect request from ID
- branch_target  in  32  redirect address
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  request accepted and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- if_pc  out  32  head-entry PC to IF/ID
- if_ins  out  32  head-entry instruction to IF/ID
- stallreq_if  out  1  queue empty, ask controller to stall
- ifq_empty_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, queue count=0, state=FETCH, counter=0.
  - While rst=1: imem_req=0, if_pc=if_ins=0, stallreq_if=0.
- Queue:
  - Entries hold {pc, ins}; circular read/write pointers; count is 0..QDEPTH.
  - if_pc/if_ins are driven combinationally from the head when count>0, else 32'h0.
  - stallreq_if = (count==0) && !branch_flag && !rst.
- Pop and push:
  - Pop at posedge when stall[0]=0, count>0, branch_flag=0.
  - A push occurs on an accepted ack (see states).
  - Push and pop may happen in the same cycle; count is unchanged in that case.
- Handshake:
  - imem_req=1 exactly in states FETCH and DISCARD; imem_addr=fetch_pc.
  - A transfer completes at a posedge with imem_req=1 and imem_ack=1; zero-wait ack (same cycle as req rise) is legal.
  - imem_addr never changes while a request is pending.
- States:
  - FETCH, no redirect:
    - On ack: push {fetch_pc, imem_rdata}, fetch_pc+=4 (wraps mod 2^32).
    - Next state is FETCH if count_next<QDEPTH, else HOLD.
    - No ack: stay.
  - FETCH + branch_flag:
    - Queue flushed (count=0, pointers reset), no pop, fetch_pc=branch_target.
    - With ack in the same cycle: data dropped, next state FETCH.
    - Without ack: next state DISCARD.
  - DISCARD:
    - imem_addr is the old (squashed) pc latched in a separate register; fetch_pc already holds the target.
    - On ack: data dropped, next state FETCH.
    - branch_flag here: fetch_pc=newer target, queue flushed, stay DISCARD (ack in the same cycle still moves to FETCH).
  - HOLD (queue full, no request):
    - Go to FETCH when count_next<QDEPTH.
    - branch_flag: flush, fetch_pc=target, next FETCH.
- Redirect cycle:
  - if_pc/if_ins forced to 32'h0 so IF/ID latches a bubble.
  - stallreq_if=0.
- stall[0]=1 does not block fetching; the queue keeps filling until full.
- Reset asserted mid-request abandons it. Memory must tolerate req dropping; any subsequent stale ack is ignored because imem_req=0.

Optional Feature:
- Macro IFQ_PERF_CNT_EN.
- Defined: ifq_empty_cnt increments (saturating at 32'hFFFF_FFFF) every cycle with rst=0, stall[0]=0, count==0; cleared by rst.
- Not defined: ifq_empty_cnt tied to 32'h0, no counter flops.

Test Plan:
- Reset then zero-wait memory (ack=1 always), stall=0:
  - imem_addr sequence is 0,4,8,…
  - if_pc shows 0 the cycle after the first ack, then 4, 8 each cycle.
  - stallreq_if=1 only on the first post-reset cycle.
- Hold stall[0]=1 for 8 cycles with zero-wait memory:
  - After 4 acks, state HOLD: imem_req=0, count=4, if_pc stays 0.
  - Release stall: pops resume, then req reasserts at 16.
- Memory with 3-cycle ack latency, branch_flag=1 with target 0x100 while the request for 0x8 is pending:
  - imem_addr holds 0x8 until ack, and that data is dropped.
  - Next imem_addr=0x100.
  - if_ins=0 in the redirect cycle.
- Redirect with queue holding 3 entries (pcs 0x20, 0x24, 0x28) and same-cycle ack:
  - All entries and the acked word are dropped; no pop.
  - Next if_pc after the refill is 0x40 for target 0x40.
- Simultaneous push and pop at count=2, stall=0, ack=1:
  - count stays 2; if_pc advances by 4.
- With IFQ_PERF_CNT_EN defined, memory withholding ack for 5 cycles after reset, stall=0:
  - ifq_empty_cnt=5 when the first entry arrives.
  - Without the macro it reads 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, runs a one-outstanding req/ack fetch,
// and feeds IF/ID from an in-order prefetch queue. Define IFQ_PERF_CNT_EN for the empty-queue counter.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_ins,
    output logic        stallreq_if,
    output logic [31:0] ifq_empty_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   discard_pc;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   q_pc  [QDEPTH];
    logic [31:0]   q_ins [QDEPTH];
    logic          ack_ok, push, pop, head_valid;

    // Only stall[0] concerns this stage; the upper bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    assign ack_ok = imem_req && imem_ack;
    assign push   = (state == FETCH) && ack_ok && !branch_flag;
    assign pop    = !stall[0] && (count != '0) && !branch_flag;

    // NOTE: a redirect flushes the queue outright, so it takes priority over push/pop.
    always_comb begin
        count_next = count;
        if (branch_flag)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // NOTE: state and datapath use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (branch_flag)
                    state_next = ack_ok ? FETCH : DISCARD;
                else if (ack_ok && count_next == FULL)
                    state_next = HOLD;
            end
            DISCARD: if (ack_ok) state_next = FETCH;
            HOLD:    if (branch_flag || count_next != FULL) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // A squashed request keeps presenting its old address until the memory acks it.
    always_comb begin
        imem_req  = !rst && (state == FETCH || state == DISCARD);
        imem_addr = (state == DISCARD) ? discard_pc : fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            discard_pc <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            count <= count_next;
            if (branch_flag) begin
                fetch_pc <= branch_target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                if (state == FETCH)
                    discard_pc <= fetch_pc;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= fetch_pc;
            q_ins[wr_ptr] <= imem_rdata;
        end
    end

    assign head_valid  = (count != '0) && !branch_flag && !rst;
    assign if_pc       = head_valid ? q_pc[rd_ptr]  : 32'h0;
    assign if_ins      = head_valid ? q_ins[rd_ptr] : 32'h0;
    assign stallreq_if = (count == '0) && !branch_flag && !rst;

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] empty_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            empty_cnt <= '0;
        else if (!stall[0] && count == '0 && empty_cnt != 32'hFFFF_FFFF)
            empty_cnt <= empty_cnt + 32'd1;
    end
    assign ifq_empty_cnt = empty_cnt;
`else
    assign ifq_empty_cnt = 32'h0;
`endif

endmodule
